// File: rtl/rx_bit_unstuffer.sv
// Receive-side NRZI decoder and bit unstuffer for the full-speed USB datapath.
// Emits one payload bit per strobe, drops stuff bits, and flags seventh-one violations.
module rx_bit_unstuffer #(
  parameter int STUFF_LEN = 6
) (
  input  logic clk,
  input  logic n_rst,
  input  logic line_in,
  input  logic bit_strobe,
  input  logic clear,
  output logic bit_out,
  output logic shift_en,
  output logic stuff_err,
  output logic rx_err
);

  localparam int CW = $clog2(STUFF_LEN + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(STUFF_LEN);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);
  localparam logic [CW-1:0] CNT_ZERO = CW'(0);

  logic [CW-1:0] ones_cnt_r;
  logic [CW-1:0] ones_cnt_s;
  logic          prev_line_r;
  logic          prev_line_s;
  logic          dec_s;
  logic          bit_s;
  logic          shift_s;
  logic          serr_s;
  logic          rx_err_s;

  // Next-state decode: clear wins, then strobe handling, otherwise hold with pulses low.
  always_comb begin
    dec_s       = ~(line_in ^ prev_line_r);
    ones_cnt_s  = ones_cnt_r;
    prev_line_s = prev_line_r;
    bit_s       = bit_out;
    rx_err_s    = rx_err;
    shift_s     = 1'b0;
    serr_s      = 1'b0;
    if (clear) begin
      ones_cnt_s  = CNT_ZERO;
      prev_line_s = 1'b1;
      bit_s       = 1'b0;
      rx_err_s    = 1'b0;
    end else if (bit_strobe) begin
      prev_line_s = line_in;
      if (ones_cnt_r == CNT_MAX) begin
        // Bit after a full run of ones is never payload; a 1 here is a violation.
        ones_cnt_s = CNT_ZERO;
        if (dec_s) begin
          serr_s   = 1'b1;
          rx_err_s = 1'b1;
        end else begin
          serr_s   = 1'b0;
        end
      end else begin
        shift_s = 1'b1;
        bit_s   = dec_s;
        if (dec_s) begin
          ones_cnt_s = ones_cnt_r + CNT_ONE;
        end else begin
          ones_cnt_s = CNT_ZERO;
        end
      end
    end else begin
      shift_s = 1'b0;
    end
  end

  // State and output registers; idle line level J is 1.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      ones_cnt_r  <= CNT_ZERO;
      prev_line_r <= 1'b1;
      bit_out     <= 1'b0;
      shift_en    <= 1'b0;
      stuff_err   <= 1'b0;
      rx_err      <= 1'b0;
    end else begin
      ones_cnt_r  <= ones_cnt_s;
      prev_line_r <= prev_line_s;
      bit_out     <= bit_s;
      shift_en    <= shift_s;
      stuff_err   <= serr_s;
      rx_err      <= rx_err_s;
    end
  end

endmodule

// File: tb/tb_rx_bit_unstuffer.sv
// Randomized bench for rx_bit_unstuffer against a queue-based model of the stuffing rules,
// with directed sequences whose pulse counts are pinned by hand-computed constants.
module tb_rx_bit_unstuffer;
  localparam int STUFF_LEN = 6;

  logic clk = 1'b0;
  logic n_rst = 1'b0;
  logic line_in = 1'b1;
  logic bit_strobe = 1'b0;
  logic clear = 1'b0;
  logic bit_out, shift_en, stuff_err, rx_err;

  rx_bit_unstuffer #(.STUFF_LEN(STUFF_LEN)) dut (
    .clk(clk), .n_rst(n_rst), .line_in(line_in), .bit_strobe(bit_strobe),
    .clear(clear), .bit_out(bit_out), .shift_en(shift_en),
    .stuff_err(stuff_err), .rx_err(rx_err)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_pass = 0;

  // Model: expected registered outputs plus the recent payload history.
  logic e_bit = 1'b0, e_shift = 1'b0, e_serr = 1'b0, e_rx = 1'b0;
  logic m_prev = 1'b1;
  bit   hist[$];
  logic cur_s = 1'b0, cur_l = 1'b1, cur_c = 1'b0;
  logic tb_line = 1'b1;

  int cnt_shift = 0, cnt_one = 0, cnt_serr = 0;

  task automatic chk(input string name, input logic act, input logic req);
    n_total++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %b expected %b at %0t", name, act, req, $time);
  endtask

  function automatic bit stuff_due();
    if (hist.size() < STUFF_LEN) return 1'b0;
    for (int i = hist.size() - STUFF_LEN; i < hist.size(); i++)
      if (!hist[i]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic model_reset();
    hist.delete();
    m_prev = 1'b1;
    e_bit = 1'b0; e_shift = 1'b0; e_serr = 1'b0; e_rx = 1'b0;
  endtask

  task automatic model_update(input logic s, input logic l, input logic c);
    logic d;
    if (c) begin
      model_reset();
    end else if (s) begin
      d = (l == m_prev);
      m_prev = l;
      e_serr = 1'b0;
      if (stuff_due()) begin
        e_shift = 1'b0;
        hist.delete();
        if (d) begin
          e_serr = 1'b1;
          e_rx = 1'b1;
        end
      end else begin
        e_shift = 1'b1;
        e_bit = d;
        hist.push_back(d);
        if (hist.size() > STUFF_LEN) void'(hist.pop_front());
      end
    end else begin
      e_shift = 1'b0;
      e_serr = 1'b0;
    end
  endtask

  // Single compare point, half a cycle after each active edge.
  always @(negedge clk) begin
    chk("bit_out", bit_out, e_bit);
    chk("shift_en", shift_en, e_shift);
    chk("stuff_err", stuff_err, e_serr);
    chk("rx_err", rx_err, e_rx);
    cnt_shift <= cnt_shift + int'(shift_en);
    cnt_one   <= cnt_one + int'(shift_en & bit_out);
    cnt_serr  <= cnt_serr + int'(stuff_err);
  end

  task automatic tick(input logic s, input logic l, input logic c);
    @(posedge clk); #2;
    if (n_rst) model_update(cur_s, cur_l, cur_c);
    cur_s = s; cur_l = l; cur_c = c;
    bit_strobe = s; line_in = l; clear = c;
  endtask

  task automatic send_d(input logic d);
    logic l;
    l = d ? tb_line : ~tb_line;
    tb_line = l;
    tick(1'b1, l, 1'b0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(1'b0, tb_line, 1'b0);
  endtask

  task automatic do_clear(input logic with_strobe);
    tick(with_strobe, 1'b0, 1'b1);
    tb_line = 1'b1;
  endtask

  task automatic pin_counts(input string name, input int s0, input int o0, input int e0,
                            input int shifts, input int ones, input int errs);
    n_total++;
    if (cnt_shift - s0 == shifts && cnt_one - o0 == ones && cnt_serr - e0 == errs) n_pass++;
    else $display("FAIL %s: shifts/ones/errs got %0d/%0d/%0d expected %0d/%0d/%0d", name,
                  cnt_shift - s0, cnt_one - o0, cnt_serr - e0, shifts, ones, errs);
  endtask

  int s0, o0, e0;
  logic [12:0] near_miss;

  initial begin
    model_reset();
    #23 n_rst = 1'b1;

    // First strobe after reset uses prev_line = 1.
    tb_line = 1'b1;
    send_d(1'b0);
    idle(1);
    chk("post_reset_shift", shift_en, 1'b1);
    chk("post_reset_bit", bit_out, 1'b0);
    idle(2);

    // Stuff removal: six ones, stuffed zero, then a one.
    do_clear(1'b0); idle(2);
    s0 = cnt_shift; o0 = cnt_one; e0 = cnt_serr;
    for (int i = 0; i < 6; i++) send_d(1'b1);
    send_d(1'b0);
    send_d(1'b1);
    idle(2);
    pin_counts("stuff_removal", s0, o0, e0, 7, 7, 0);

    // Violation: seven ones; sticky flag through idle, then clear.
    do_clear(1'b0); idle(2);
    s0 = cnt_shift; o0 = cnt_one; e0 = cnt_serr;
    for (int i = 0; i < 7; i++) send_d(1'b1);
    idle(21);
    chk("rx_err_sticky", rx_err, 1'b1);
    pin_counts("violation", s0, o0, e0, 6, 6, 1);
    do_clear(1'b0); idle(1);
    chk("rx_err_cleared", rx_err, 1'b0);
    idle(1);

    // Near-miss run: only the last zero is a stuff bit.
    near_miss = 13'b0_1111_1101_1111;
    s0 = cnt_shift; o0 = cnt_one; e0 = cnt_serr;
    for (int i = 0; i < 13; i++) send_d(near_miss[i]);
    idle(2);
    pin_counts("near_miss", s0, o0, e0, 12, 11, 0);

    // Clear mid-run with a coincident strobe, which must be discarded.
    do_clear(1'b0); idle(1);
    s0 = cnt_shift; o0 = cnt_one; e0 = cnt_serr;
    for (int i = 0; i < 4; i++) send_d(1'b1);
    do_clear(1'b1);
    idle(1);
    chk("prio_shift", shift_en, 1'b0);
    chk("prio_serr", stuff_err, 1'b0);
    for (int i = 0; i < 3; i++) send_d(1'b1);
    idle(2);
    pin_counts("clear_mid_run", s0, o0, e0, 7, 7, 0);
    do_clear(1'b0);
    tick(1'b1, 1'b0, 1'b0); tb_line = 1'b0;
    idle(1);
    chk("after_clear_bit", bit_out, 1'b0);
    chk("after_clear_shift", shift_en, 1'b1);

    // Asynchronous reset while shift_en is high.
    for (int i = 0; i < 3; i++) send_d(1'b1);
    chk("pre_reset_shift", shift_en, 1'b1);
    tick(1'b1, tb_line, 1'b0);
    n_rst = 1'b0;
    model_reset();
    #1;
    chk("async_rst_shift", shift_en, 1'b0);
    chk("async_rst_bit", bit_out, 1'b0);
    chk("async_rst_rx", rx_err, 1'b0);
    idle(2);
    @(posedge clk); #2 n_rst = 1'b1;
    tb_line = 1'b1;
    cur_s = 1'b0; bit_strobe = 1'b0;

    // Randomized traffic biased towards long runs of ones.
    for (int i = 0; i < 3000; i++) begin
      int r;
      r = $urandom_range(0, 99);
      if (r < 2) do_clear($urandom_range(0, 1) == 1);
      else if (r < 25) idle(1);
      else send_d($urandom_range(0, 99) < 85);
    end
    idle(3);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
